// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port among NREQ writeback
//   requesters using round-robin arbitration with a valid/ready handshake.
//   A single registered output stage drives the register file directly and
//   doubles as the forwarding source for the in-flight write. Writes to x0
//   are acknowledged but never reach the register file.
// Ports
//   clk        clock, all state on posedge
//   rst        synchronous reset, active-high
//   req_valid  per-requester write pending
//   req_ready  per-requester write accepted this cycle (one-hot or zero)
//   req_addr   packed dest indices, slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data   packed write data,   slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   rf_wen     register-file write enable
//   rf_waddr   register-file write index
//   rf_wdata   register-file write data
//   grant_id   requester that owns the current rf_* write
//   fwd_valid  rf_wdata is forwardable to readers of rf_waddr (= rf_wen)
module regfile_wb_arbiter #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       fwd_valid
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW-1:0]        rr_ptr;
  logic [IDW-1:0]        win_idx;
  logic [IDW-1:0]        ptr_next;
  logic                  win_found;
  logic                  transfer;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  logic [ADDR_WIDTH-1:0] addr_arr [NREQ];
  logic [DATA_WIDTH-1:0] data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // (base + inc) mod NREQ; both operands are already below NREQ, so a
  // single conditional subtract suffices even for non-power-of-two NREQ.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                              input logic [IDW-1:0] inc);
    logic [IDW:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    return sum[IDW-1:0];
  endfunction

  // Scan from rr_ptr upward (modulo NREQ); first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    ptr_next  = rr_ptr;
    win_addr  = '0;
    win_data  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!win_found && req_valid[wrap_add(rr_ptr, IDW'(k))]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(rr_ptr, IDW'(k));
        win_addr  = addr_arr[wrap_add(rr_ptr, IDW'(k))];
        win_data  = data_arr[wrap_add(rr_ptr, IDW'(k))];
        ptr_next  = wrap_add(wrap_add(rr_ptr, IDW'(k)), IDW'(1));
      end
    end
    transfer  = win_found & ~rst;
    req_ready = '0;
    if (transfer) req_ready[win_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      grant_id <= '0;
    end else if (transfer) begin
      rr_ptr   <= ptr_next;
      grant_id <= win_idx;
      // x0 writes are acknowledged but presented as a cleared, disabled write.
      if (win_addr == '0) begin
        rf_wen   <= 1'b0;
        rf_waddr <= '0;
        rf_wdata <= '0;
      end else begin
        rf_wen   <= 1'b1;
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
      end
    end else begin
      rf_wen <= 1'b0;
    end
  end

  assign fwd_valid = rf_wen;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Self-checking bench for regfile_wb_arbiter. Two instances: NREQ=2
//   (default parameters) and NREQ=3. A vector table gives per-cycle inputs
//   and the expected one-hot req_ready; the expected registered rf_* values
//   are derived from that row and queued, then popped and compared one edge
//   later.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // NREQ=2 instance
  logic         rst2;
  logic [1:0]   valid2, ready2;
  logic [9:0]   addr2;
  logic [127:0] data2;
  logic         wen2, fwd2;
  logic [4:0]   waddr2;
  logic [63:0]  wdata2;
  logic [0:0]   gid2;

  // NREQ=3 instance
  logic         rst3;
  logic [2:0]   valid3, ready3;
  logic [14:0]  addr3;
  logic [191:0] data3;
  logic         wen3, fwd3;
  logic [4:0]   waddr3;
  logic [63:0]  wdata3;
  logic [1:0]   gid3;

  regfile_wb_arbiter #(.NREQ(2), .ADDR_WIDTH(5), .DATA_WIDTH(64)) dut2 (
    .clk(clk), .rst(rst2), .req_valid(valid2), .req_ready(ready2),
    .req_addr(addr2), .req_data(data2), .rf_wen(wen2), .rf_waddr(waddr2),
    .rf_wdata(wdata2), .grant_id(gid2), .fwd_valid(fwd2)
  );

  regfile_wb_arbiter #(.NREQ(3), .ADDR_WIDTH(5), .DATA_WIDTH(64)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(valid3), .req_ready(ready3),
    .req_addr(addr3), .req_data(data3), .rf_wen(wen3), .rf_waddr(waddr3),
    .rf_wdata(wdata3), .grant_id(gid3), .fwd_valid(fwd3)
  );

  typedef struct {
    int          sel;     // 0 -> dut2, 1 -> dut3
    logic        rst;
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [63:0] d0, d1, d2;
    logic [2:0]  rdy;     // expected req_ready this cycle
  } vec_t;

  typedef struct {
    int          sel;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  gid;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state for the idle-cycle hold of rf_waddr/rf_wdata/grant_id.
  logic [4:0]  m_addr [2];
  logic [63:0] m_data [2];
  logic [1:0]  m_gid  [2];

  task automatic add(input int sel, input logic rst, input logic [2:0] valid,
                     input logic [4:0] a0, input logic [63:0] d0,
                     input logic [4:0] a1, input logic [63:0] d1,
                     input logic [4:0] a2, input logic [63:0] d2,
                     input logic [2:0] rdy);
    vec_t v;
    v.sel = sel; v.rst = rst; v.valid = valid;
    v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.rdy = rdy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  // Expected rf_* after the edge that ends the cycle described by v.
  function automatic exp_t predict(input vec_t v);
    exp_t e;
    int w;
    logic [4:0]  a [3];
    logic [63:0] d [3];
    a[0] = v.a0; a[1] = v.a1; a[2] = v.a2;
    d[0] = v.d0; d[1] = v.d1; d[2] = v.d2;
    e.sel = v.sel;
    w = -1;
    for (int j = 0; j < 3; j++) if (v.rdy[j]) w = j;
    if (v.rst) begin
      e.wen = 1'b0; e.waddr = '0; e.wdata = '0; e.gid = '0;
    end else if (w >= 0) begin
      e.gid = 2'(w);
      if (a[w] == 5'd0) begin
        e.wen = 1'b0; e.waddr = '0; e.wdata = '0;
      end else begin
        e.wen = 1'b1; e.waddr = a[w]; e.wdata = d[w];
      end
    end else begin
      e.wen   = 1'b0;
      e.waddr = m_addr[v.sel];
      e.wdata = m_data[v.sel];
      e.gid   = m_gid[v.sel];
    end
    return e;
  endfunction

  initial begin
    exp_t e;
    vec_t v;
    logic [2:0] act_rdy;

    rst2 = 1'b1; valid2 = '0; addr2 = '0; data2 = '0;
    rst3 = 1'b1; valid3 = '0; addr3 = '0; data3 = '0;
    for (int s = 0; s < 2; s++) begin
      m_addr[s] = '0; m_data[s] = '0; m_gid[s] = '0;
    end

    // ---- NREQ=2 ----
    // Reset with both valid: no ready.
    add(0, 1, 3'b011, 1, 'h10, 2, 'h20, 0, 0, 3'b000);
    add(0, 1, 3'b011, 1, 'h10, 2, 'h20, 0, 0, 3'b000);
    // Contention from rr_ptr=0: 0,1,0,1 with per-requester addresses.
    add(0, 0, 3'b011, 1, 'h10, 2, 'h20, 0, 0, 3'b001);
    add(0, 0, 3'b011, 3, 'h30, 2, 'h20, 0, 0, 3'b010);
    add(0, 0, 3'b011, 3, 'h30, 4, 'h40, 0, 0, 3'b001);
    add(0, 0, 3'b011, 5, 'h50, 4, 'h40, 0, 0, 3'b010);
    add(0, 0, 3'b000, 5, 'h50, 4, 'h40, 0, 0, 3'b000);
    // Single write, one-cycle rf_wen pulse.
    add(0, 0, 3'b001, 5, 'hDEAD, 0, 0, 0, 0, 3'b001);
    add(0, 0, 3'b000, 5, 'hDEAD, 0, 0, 0, 0, 3'b000);
    // x0 write from req1, then normal write from req0.
    add(0, 0, 3'b010, 0, 0, 0, 'hFFFF, 0, 0, 3'b010);
    add(0, 0, 3'b001, 3, 'h33, 0, 0, 0, 0, 3'b001);
    add(0, 0, 3'b010, 0, 0, 9, 'h99, 0, 0, 3'b010);
    // Grant req0, then reset mid-stream with req1 pending.
    add(0, 0, 3'b001, 7, 'h77, 8, 'h88, 0, 0, 3'b001);
    add(0, 1, 3'b010, 7, 'h77, 8, 'h88, 0, 0, 3'b000);
    add(0, 1, 3'b010, 7, 'h77, 8, 'h88, 0, 0, 3'b000);
    add(0, 0, 3'b011, 7, 'h77, 8, 'h88, 0, 0, 3'b001);
    add(0, 0, 3'b010, 7, 'h77, 8, 'h88, 0, 0, 3'b010);
    add(0, 0, 3'b000, 7, 'h77, 8, 'h88, 0, 0, 3'b000);

    // ---- NREQ=3: wrap and drop of a middle requester ----
    add(1, 1, 3'b111, 1, 'h11, 2, 'h22, 3, 'h33, 3'b000);
    add(1, 0, 3'b111, 1, 'h11, 2, 'h22, 3, 'h33, 3'b001);
    add(1, 0, 3'b111, 1, 'h11, 2, 'h22, 3, 'h33, 3'b010);
    add(1, 0, 3'b111, 1, 'h11, 2, 'h22, 3, 'h33, 3'b100);
    add(1, 0, 3'b111, 1, 'h11, 2, 'h22, 3, 'h33, 3'b001);
    add(1, 0, 3'b101, 1, 'h11, 2, 'h22, 3, 'h33, 3'b100);
    add(1, 0, 3'b101, 1, 'h11, 2, 'h22, 3, 'h33, 3'b001);
    add(1, 0, 3'b101, 1, 'h11, 2, 'h22, 3, 'h33, 3'b100);
    add(1, 0, 3'b101, 1, 'h11, 2, 'h22, 3, 'h33, 3'b001);
    add(1, 0, 3'b000, 1, 'h11, 2, 'h22, 3, 'h33, 3'b000);

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      if (v.sel == 0) begin
        rst2 = v.rst; valid2 = v.valid[1:0];
        addr2 = {v.a1, v.a0}; data2 = {v.d1, v.d0};
        rst3 = 1'b1; valid3 = '0;
      end else begin
        rst3 = v.rst; valid3 = v.valid;
        addr3 = {v.a2, v.a1, v.a0}; data3 = {v.d2, v.d1, v.d0};
        rst2 = 1'b1; valid2 = '0;
      end
      #1;
      act_rdy = (v.sel == 0) ? {1'b0, ready2} : ready3;
      chk("req_ready", i, 64'(act_rdy), 64'(v.rdy));

      e = predict(v);
      sb.push_back(e);
      m_addr[v.sel] = e.waddr;
      m_data[v.sel] = e.wdata;
      m_gid[v.sel]  = e.gid;

      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", i);
      end else begin
        e = sb.pop_front();
        if (e.sel == 0) begin
          chk("rf_wen",    i, 64'(wen2),   64'(e.wen));
          chk("fwd_valid", i, 64'(fwd2),   64'(e.wen));
          chk("rf_waddr",  i, 64'(waddr2), 64'(e.waddr));
          chk("rf_wdata",  i, wdata2,      e.wdata);
          chk("grant_id",  i, 64'(gid2),   64'(e.gid));
        end else begin
          chk("rf_wen",    i, 64'(wen3),   64'(e.wen));
          chk("fwd_valid", i, 64'(fwd3),   64'(e.wen));
          chk("rf_waddr",  i, 64'(waddr3), 64'(e.waddr));
          chk("rf_wdata",  i, wdata3,      e.wdata);
          chk("grant_id",  i, 64'(gid3),   64'(e.gid));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
